// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if: line-start, config-read and slot-table signals of the sprite line scheduler.
interface sprite_line_scheduler_if #(
    parameter int MAX_PER_LINE = 8
);
    localparam int SW = MAX_PER_LINE > 1 ? $clog2(MAX_PER_LINE) : 1;
    logic                    line_start;
    logic [8:0]              next_line;
    logic                    cfg_rd;
    logic [5:0]              cfg_addr;
    logic [31:0]             cfg_data;
    logic [SW-1:0]           slot_rd_idx;
    logic [31:0]             slot_cfg;
    logic [MAX_PER_LINE-1:0] slot_valid;
    logic [3:0]              slot_count;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    modport slave (
        input  line_start, next_line, cfg_data, slot_rd_idx,
        output cfg_rd, cfg_addr, slot_cfg, slot_valid, slot_count, busy, done, overflow
    );
    modport master (
        output line_start, next_line, cfg_data, slot_rd_idx,
        input  cfg_rd, cfg_addr, slot_cfg, slot_valid, slot_count, busy, done, overflow
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans sprite configs for the next line and collects up to MAX_PER_LINE hits into a slot table.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES  = 64,
    parameter int MAX_PER_LINE = 8
) (
    input logic clk,
    input logic reset,
    sprite_line_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
    localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
    localparam int SW = MAX_PER_LINE > 1 ? $clog2(MAX_PER_LINE) : 1;
    logic [1:0]              r_state;
    logic [IW-1:0]           r_idx;
    logic [8:0]              r_line;
    logic                    r_pend;
    logic [31:0]             r_slot [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] r_valid;
    logic [3:0]              r_count;
    logic                    r_ovf;
    logic                    w_eval, w_hit, w_full, w_store, w_ovf_hit, w_last;
    logic [8:0]              w_top;
    // The upper bound wraps in 9 bits, so sprites near the bottom never match.
    assign w_top     = bus.cfg_data[8:0] + 9'd16;
    assign w_eval    = r_pend && (r_state == SCAN || r_state == FLUSH);
    assign w_hit     = w_eval && bus.cfg_data[28] && r_line >= bus.cfg_data[8:0] && r_line < w_top;
    assign w_full    = r_count == 4'(MAX_PER_LINE);
    assign w_store   = w_hit && !w_full;
    assign w_ovf_hit = w_hit && w_full;
    assign w_last    = r_idx == IW'(NUM_SPRITES - 1);
    assign bus.cfg_rd     = r_state == SCAN;
    assign bus.cfg_addr   = bus.cfg_rd ? 6'(r_idx) : 6'd0;
    assign bus.busy       = r_state == SCAN || r_state == FLUSH;
    assign bus.done       = r_state == DONE;
    assign bus.overflow   = r_ovf;
    assign bus.slot_valid = r_valid;
    assign bus.slot_count = r_count;
    assign bus.slot_cfg   = r_valid[bus.slot_rd_idx] ? r_slot[bus.slot_rd_idx] : 32'd0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_line  <= '0;
            r_pend  <= 1'b0;
            r_valid <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int n = 0; n < MAX_PER_LINE; n++) r_slot[n] <= '0;
        end else if (bus.line_start) begin
            r_state <= SCAN;
            r_idx   <= '0;
            r_line  <= bus.next_line;
            r_pend  <= 1'b0;
            r_valid <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            // A read issued in the cycle overflow is found is dropped.
            r_pend <= bus.cfg_rd && !w_ovf_hit;
            if (w_store) begin
                r_slot[r_count[SW-1:0]]  <= bus.cfg_data;
                r_valid[r_count[SW-1:0]] <= 1'b1;
                r_count                  <= r_count + 4'd1;
            end
            if (w_ovf_hit) r_ovf <= 1'b1;
            if (r_state == SCAN) begin
                r_idx <= r_idx + 1'b1;
                if (w_last || w_ovf_hit) r_state <= FLUSH;
            end else if (r_state == FLUSH) r_state <= DONE;
            else if (r_state == DONE) r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: table vectors and corner sequences, checked against a scoreboard of modelled scan results.
module tb_sprite_line_scheduler;
    localparam int N = 64;
    localparam int M = 8;
    typedef struct {
        int          cnt;
        logic        ovf;
        logic [7:0]  valid;
        logic [31:0] slots [M];
        int          off;
    } exp_t;
    typedef struct {
        logic [8:0] line;
        logic [8:0] ypos;
        logic       en;
        int         cnt;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem [N];
    int          cyc = 0, checks = 0, errors = 0, dones = 0, max_addr = 0;
    exp_t        sb [$];
    vec_t        vecs [11];
    sprite_line_scheduler_if #(.MAX_PER_LINE(M)) bus ();
    sprite_line_scheduler #(.NUM_SPRITES(N), .MAX_PER_LINE(M)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Config memory with one-cycle latency; idle cycles return a word that would hit line 100.
    always @(posedge clk) bus.cfg_data <= bus.cfg_rd ? mem[bus.cfg_addr] : 32'h1000_0064;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask
    always @(negedge clk) begin
        if (bus.done) dones++;
        if (bus.cfg_rd && int'(bus.cfg_addr) > max_addr) max_addr = int'(bus.cfg_addr);
        if (!reset && !bus.cfg_rd) check("addr_idle_zero", 32'(bus.cfg_addr), 32'd0);
    end
    function automatic exp_t model(input logic [8:0] line);
        exp_t e;
        e.cnt = 0;
        e.ovf = 1'b0;
        e.valid = '0;
        e.off = N + 1;
        for (int n = 0; n < M; n++) e.slots[n] = '0;
        for (int k = 0; k < N; k++) begin
            int y = int'(mem[k][8:0]);
            int l = int'(line);
            if (!e.ovf && mem[k][28] && y < 496 && l >= y && l <= y + 15) begin
                if (e.cnt == M) begin
                    e.ovf = 1'b1;
                    e.off = (3 + k < N + 1) ? 3 + k : N + 1;
                end else begin
                    e.slots[e.cnt] = mem[k];
                    e.valid[e.cnt] = 1'b1;
                    e.cnt++;
                end
            end
        end
        return e;
    endfunction
    task automatic start(input logic [8:0] line, input bit push, output int ts);
        @(negedge clk);
        if (push) sb.push_back(model(line));
        max_addr = 0;
        bus.line_start = 1'b1;
        bus.next_line = line;
        @(negedge clk);
        bus.line_start = 1'b0;
        ts = cyc;
    endtask
    task automatic finish(input int ts);
        exp_t e;
        int i;
        for (i = 0; i < 200 && !bus.done; i++) @(negedge clk);
        e = sb.pop_front();
        if (!bus.done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_cycle", 32'(cyc - ts), 32'(e.off));
            check("busy_at_done", 32'(bus.busy), 32'd0);
            check("slot_count", 32'(bus.slot_count), 32'(e.cnt));
            check("slot_valid", 32'(bus.slot_valid), 32'(e.valid));
            check("overflow", 32'(bus.overflow), 32'(e.ovf));
            @(negedge clk);
            check("done_one_cycle", 32'(bus.done), 32'd0);
            for (int n = 0; n < M; n++) begin
                bus.slot_rd_idx = 3'(n);
                #1;
                check($sformatf("slot_cfg[%0d]", n), bus.slot_cfg, e.slots[n]);
            end
        end
    endtask
    task automatic fill_disabled(input logic [8:0] line);
        for (int k = 0; k < N; k++) mem[k] = 32'(line);
    endtask
    initial begin
        int ts, d0;
        bus.line_start = 1'b0;
        bus.next_line = '0;
        bus.slot_rd_idx = '0;
        fill_disabled(9'd0);
        vecs = '{
            '{9'd115, 9'd100, 1'b1, 1}, '{9'd116, 9'd100, 1'b1, 0}, '{9'd100, 9'd100, 1'b0, 0},
            '{9'd505, 9'd500, 1'b1, 0}, '{9'd0,   9'd0,   1'b1, 1}, '{9'd100, 9'd100, 1'b1, 1},
            '{9'd99,  9'd100, 1'b1, 0}, '{9'd511, 9'd496, 1'b1, 0}, '{9'd495, 9'd480, 1'b1, 1},
            '{9'd20,  9'd5,   1'b1, 1}, '{9'd21,  9'd5,   1'b1, 0}
        };
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cfg_rd", 32'(bus.cfg_rd), 32'd0);
        check("rst_count", 32'(bus.slot_count), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_scan", 32'(bus.busy), 32'd0);
        for (int v = 0; v < 11; v++) begin
            fill_disabled(vecs[v].line);
            mem[5] = {3'b0, vecs[v].en, 19'h0AB, vecs[v].ypos};
            start(vecs[v].line, 1'b1, ts);
            finish(ts);
            check($sformatf("vec%0d_hits", v), 32'(bus.slot_count), 32'(vecs[v].cnt));
        end
        fill_disabled(9'd100);
        mem[3] = 32'h1ABC_0064;
        mem[10] = 32'h3123_405A;
        start(9'd100, 1'b1, ts);
        finish(ts);
        check("two_hits_count", 32'(bus.slot_count), 32'd2);
        fill_disabled(9'd55);
        for (int k = 0; k < 10; k++) mem[k] = 32'h1000_0032 | (32'(k) << 16);
        start(9'd55, 1'b1, ts);
        finish(ts);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_last_addr", 32'(max_addr), 32'd9);
        d0 = dones;
        start(9'd100, 1'b0, ts);
        repeat (18) @(negedge clk);
        start(9'd55, 1'b1, ts);
        check("abort_no_done", 32'(dones - d0), 32'd0);
        finish(ts);
        check("restart_one_done", 32'(dones - d0), 32'd1);
        fill_disabled(9'd100);
        mem[3] = 32'h1ABC_0064;
        mem[10] = 32'h3123_405A;
        start(9'd100, 1'b0, ts);
        repeat (28) @(negedge clk);
        check("pre_reset_count", 32'(bus.slot_count), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_cfg_rd", 32'(bus.cfg_rd), 32'd0);
        check("ar_cfg_addr", 32'(bus.cfg_addr), 32'd0);
        check("ar_count", 32'(bus.slot_count), 32'd0);
        check("ar_valid", 32'(bus.slot_valid), 32'd0);
        check("ar_ovf", 32'(bus.overflow), 32'd0);
        check("ar_done", 32'(bus.done), 32'd0);
        bus.slot_rd_idx = 3'd0;
        #1 check("ar_slot_cfg", bus.slot_cfg, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d0 = dones;
        repeat (80) @(negedge clk);
        check("post_reset_no_done", 32'(dones - d0), 32'd0);
        start(9'd100, 1'b1, ts);
        finish(ts);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
